// File: rtl/mask_deserializer.sv
// Rebuilds one mask row from a column-interleaved stream of lane-wide beats.
// On beat c, lane i carries row bit i*step + c; a completed row is held on DOUT with a done pulse.
module mask_deserializer #(
   parameter int IP_CHANNEL_WIDTH = 20,
   parameter int OP_CHANNEL_WIDTH = 1080,
   parameter int stepSel0         = 16,
   parameter int stepSel1         = 32,
   parameter int stepSel2         = 54
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        valid,
   input  logic [IP_CHANNEL_WIDTH-1:0] DIN,
   input  logic [1:0]                  imageResolution,
   input  logic                        flush,
   output logic [OP_CHANNEL_WIDTH-1:0] DOUT,
   output logic                        done,
   output logic                        busy
);

   localparam int IDX_W = $clog2(OP_CHANNEL_WIDTH);

   logic [5:0]                  cnt;
   logic [5:0]                  cnt_next;
   logic [5:0]                  step_q;
   logic [5:0]                  step_eff;
   logic                        last_beat;
   logic                        accept;
   logic [IDX_W-1:0]            idx;
   logic [OP_CHANNEL_WIDTH-1:0] w_q;
   logic [OP_CHANNEL_WIDTH-1:0] w_next;

   // Encoding 2'b11 is reserved and decodes like 2'b01.
   function automatic logic [5:0] step_decode(input logic [1:0] res);
      case (res)
         2'b00:   return 6'(stepSel0);
         2'b10:   return 6'(stepSel2);
         default: return 6'(stepSel1);
      endcase
   endfunction

   // Resolution is only honoured on the first beat; afterwards the latched step rules the row.
   always_comb begin
      step_eff  = (cnt == 6'd0) ? step_decode(imageResolution) : step_q;
      last_beat = (cnt == step_eff - 6'd1);
      accept    = valid && !flush;
      w_next    = (cnt == 6'd0) ? '0 : w_q;
      idx       = '0;
      for (int i = 0; i < IP_CHANNEL_WIDTH; i++) begin
         idx         = IDX_W'(i) * IDX_W'(step_eff) + IDX_W'(cnt);
         w_next[idx] = DIN[i];
      end
   end

   always_comb begin
      if (flush)
         cnt_next = 6'd0;
      else if (valid)
         cnt_next = last_beat ? 6'd0 : cnt + 6'd1;
      else
         cnt_next = cnt;
   end

   // The final beat goes straight into DOUT so the row appears at the edge sampling it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= 6'd0;
         step_q <= 6'(stepSel1);
         w_q    <= '0;
         DOUT   <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         busy <= (cnt_next != 6'd0);
         done <= accept && last_beat;
         if (accept) begin
            if (cnt == 6'd0)
               step_q <= step_eff;
            if (last_beat)
               DOUT <= w_next;
            else
               w_q <= w_next;
         end
      end
   end

endmodule

// File: tb/tb_mask_deserializer.sv
// Randomized scoreboard bench for mask_deserializer: rows are serialized from known vectors,
// expected rows are queued at issue time and a negedge monitor checks DOUT/done/busy.
module tb_mask_deserializer;

   localparam int LW = 20;
   localparam int RW = 1080;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0;
   logic          flush = 1'b0;
   logic [LW-1:0] DIN = '0;
   logic [1:0]    imageResolution = 2'b01;
   logic [RW-1:0] DOUT;
   logic          done;
   logic          busy;

   int            total = 0;
   int            bad = 0;
   int            mcnt = 0;
   int            mstep = 32;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] exp_dout = '0;

   always #5 clk = ~clk;

   mask_deserializer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .valid           (valid),
      .DIN             (DIN),
      .imageResolution (imageResolution),
      .flush           (flush),
      .DOUT            (DOUT),
      .done            (done),
      .busy            (busy)
   );

   function automatic int step_of(input logic [1:0] r);
      case (r)
         2'b00:   return 16;
         2'b10:   return 54;
         default: return 32;
      endcase
   endfunction

   function automatic logic [RW-1:0] mask_of(input int st);
      logic [RW-1:0] m;
      m = '0;
      for (int k = 0; k < LW * st; k++) m[k] = 1'b1;
      return m;
   endfunction

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      r = '0;
      for (int k = 0; k < 34; k++) r = {r[RW-33:0], 32'($urandom)};
      return r;
   endfunction

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s t=%0t actual_lo=%0h required_lo=%0h differing_bits=%0d",
                  name, $time, act[63:0], req[63:0], $countones(act ^ req));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL done_unexpected t=%0t actual=1 required=0", $time);
            end else begin
               exp_dout = exp_q.pop_front();
            end
         end
         check("dout", DOUT, exp_dout);
         check("busy", RW'(busy), RW'(mcnt != 0));
      end
   end

   // One clock of stimulus; the model beat count follows the row rules.
   task automatic beat(input logic [LW-1:0] d, input logic [1:0] r, input logic v, input logic f);
      valid = v;
      DIN = d;
      imageResolution = r;
      flush = f;
      @(posedge clk);
      #1;
      if (f) mcnt = 0;
      else if (v) begin
         if (mcnt == 0) mstep = step_of(r);
         if (mcnt == mstep - 1) mcnt = 0;
         else mcnt++;
      end
      valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) beat(LW'($urandom), 2'($urandom), 1'b0, 1'b0);
   endtask

   task automatic send_row(input logic [1:0] res, input logic [RW-1:0] row, input int flush_at,
                           input int gap_a, input int gap_b, input int tog_at);
      int            st;
      logic [LW-1:0] d;
      logic [1:0]    r;
      st = step_of(res);
      for (int c = 0; c < st; c++) begin
         for (int i = 0; i < LW; i++) d[i] = row[i*st+c];
         r = (tog_at > 0 && c >= tog_at) ? 2'b10 : res;
         if (c == st - 1 && c != flush_at) exp_q.push_back(row & mask_of(st));
         beat(d, r, 1'b1, c == flush_at);
         if (c == flush_at) return;
         if (c == gap_a || c == gap_b) idle(5);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [RW-1:0] row;
      logic [LW-1:0] d;
      logic [1:0]    r;
      int            fa;

      #3;
      check("reset_dout", DOUT, '0);
      check("reset_done", RW'(done), '0);
      check("reset_busy", RW'(busy), '0);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;

      row = rand_row();
      row[639:0] = {10{64'h0123456789abcdef}};
      send_row(2'b01, row, -1, -1, -1, 0);
      send_row(2'b00, '1, -1, -1, -1, 0);
      send_row(2'b10, rand_row(), -1, -1, -1, 0);
      send_row(2'b11, rand_row(), -1, -1, -1, 0);
      idle(2);

      send_row(2'b01, rand_row(), -1, 3, 20, 7);
      idle(1);

      send_row(2'b01, rand_row(), 10, -1, -1, 0);
      idle(2);
      send_row(2'b01, rand_row(), -1, -1, -1, 0);
      send_row(2'b00, rand_row(), 15, -1, -1, 0);
      idle(2);
      send_row(2'b00, rand_row(), -1, -1, -1, 0);

      send_row(2'b01, rand_row(), -1, -1, -1, 0);
      send_row(2'b00, rand_row(), -1, -1, -1, 0);
      idle(3);

      // Asynchronous reset in the middle of beat 15 of a row.
      row = rand_row();
      for (int c = 0; c < 15; c++) begin
         for (int i = 0; i < LW; i++) d[i] = row[i*32+c];
         beat(d, 2'b01, 1'b1, 1'b0);
      end
      for (int i = 0; i < LW; i++) d[i] = row[i*32+15];
      valid = 1'b1;
      DIN = d;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      exp_dout = '0;
      mcnt = 0;
      #1;
      check("async_rst_dout", DOUT, '0);
      check("async_rst_done", RW'(done), '0);
      check("async_rst_busy", RW'(busy), '0);
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_row(2'b01, rand_row(), -1, -1, -1, 0);

      for (int n = 0; n < 14; n++) begin
         r = 2'($urandom);
         fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, step_of(r) - 1) : -1;
         send_row(r, rand_row(), fa, $urandom_range(0, 60), -1, 0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      idle(3);
      check("queue_drained", RW'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mask_deserializer.md
# mask_deserializer

Receive-side counterpart of the mask serializer: collects a column-interleaved stream of LANE-wide beats and rebuilds one full mask row. On beat c, lane i carries row bit i*step + c. step is 16, 32 or 54 beats per row, chosen by imageResolution. The completed row is presented on a held output register with a one-cycle done pulse.

## Interface
- IP_CHANNEL_WIDTH, 20, beat width (lanes); input stream width.
- OP_CHANNEL_WIDTH, 1080, row width; must be >= IP_CHANNEL_WIDTH*stepSel2.
- stepSel0, 16, beats per row for imageResolution 2'b00.
- stepSel1, 32, beats per row for imageResolution 2'b01 and 2'b11 (11 is reserved and aliases 01).
- stepSel2, 54, beats per row for imageResolution 2'b10.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid  in  1  DIN carries a beat this cycle.
- DIN  in  IP_CHANNEL_WIDTH  beat data; lane i is DIN[i].
- imageResolution  in  2  row format select; sampled only on the first beat of a row.
- flush  in  1  synchronous abort of the partial row.
- DOUT  out  OP_CHANNEL_WIDTH  last completed row; held until the next row completes.
- done  out  1  one-cycle pulse: DOUT was updated by the previous edge.
- busy  out  1  a row is partially assembled (beat count != 0).

## Operation
- State: beat counter cnt (0..53, 6 bits), latched step register, working row register W, output register DOUT.
- Idle or row start (cnt==0) with valid=1:
  - Latch step from imageResolution.
  - Clear W, then write DIN[i] to W[i*step + 0].
  - Set cnt=1.
- Mid-row (0<cnt<step-1) with valid=1: write W[i*step + cnt] = DIN[i] for all i, then cnt++.
- Last beat (cnt==step-1) with valid=1: form the final row as W plus this beat and load it into DOUT. Assert done next cycle. Set cnt=0.
- DOUT bits at or above IP_CHANNEL_WIDTH*step read 0. Example: with step 16, DOUT[1079:320]=0.
- valid=0: W and cnt hold. There is no timeout and gaps of any length are allowed.
- imageResolution changes while cnt!=0 are ignored. The new value takes effect on the next row's first beat.
- flush=1: cnt=0, the partial row is discarded, DOUT and done are unaffected.
  - flush and valid in the same cycle: flush wins and the beat is dropped.
  - flush on a last-beat cycle: the row is discarded and done does not pulse.
- Back-to-back rows are supported. A first beat in the cycle right after a last beat starts the new row with no bubble while done is high.
- Latched step 16/32/54 bounds every index below IP_CHANNEL_WIDTH*stepSel2 for all legal inputs, so no write goes out of range.

## Timing
- Reset (rst_n low, asynchronous): cnt=0, step=stepSel1, W=0, DOUT=0, done=0, busy=0. Takes effect immediately, including mid-row. The partial row is lost.
- Latency: DOUT and done change at the rising edge that samples the last beat. That is step accepted beats after row start, with no extra pipeline stage.
- done is high for exactly one cycle per completed row and is never asserted by reset or flush.
- busy is registered and equals (cnt!=0).
- Throughput: one beat per cycle. A row takes step cycles when valid is held high.
- All outputs come straight from registers, with no combinational path from inputs.

## Test plan
- Row at imageResolution=01: serialize a known 640-bit pattern (e.g. row = 640'h0123…cdef repeated) with lanes i*32+c over 32 contiguous beats.
  - DOUT[639:0] must equal the pattern and DOUT[1079:640]=0.
  - done goes high once, the cycle after beat 31.
  - busy falls at the same edge as done rises.
- imageResolution=00 and 10:
  - 16 beats of all-ones → DOUT[319:0] all 1, the rest 0.
  - 54 beats of a random 1080-bit row → exact match.
  - 2'b11 behaves as 32 beats.
- Gaps and mid-row resolution change: row at 01 with valid low for 5 cycles after beats 3 and 20, and imageResolution toggled to 10 at beat 7.
  - The row still completes after 32 beats with the correct DOUT.
  - No done pulse occurs early.
- Flush:
  - flush with valid at beat 10 → busy=0, DOUT keeps the previous row, no done. A following full row reconstructs correctly.
  - flush on the last beat → no done.
- Back-to-back rows: row A at 01 followed immediately by row B at 00, valid held high.
  - done pulses after 32 and after 48 total beats.
  - DOUT shows A during the 16 beats of B, then B with bits ≥320 zero.
- Reset: assert rst_n low at beat 15 of a row, asynchronously between edges.
  - DOUT=0, done=0 and busy=0 immediately.
  - After release, a full row at 01 reconstructs correctly.
